uart_tx_fifo: RTL and testbench

Byte FIFO sitting directly upstream of the UART transmit state machine. The host side writes bytes in. The tx core reads one byte as it enters the start-bit state, and uses the empty flag as its "data available" condition. The block also provides a fill level, an almost-full warning, and sticky overflow/underflow error flags for the register interface.

---
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmit state machine: fill level, almost-full and sticky error flags.
// Define UART_TX_FIFO_TMR_EN to triplicate the pointers and count with 2-of-3 majority voting.
module uart_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_WrEn_i,
    input  logic [DATA_WIDTH-1:0] WrData_i,
    input  logic                  p_RdEn_i,
    input  logic                  p_ErrClr_i,
    output logic [DATA_WIDTH-1:0] RdData_o,
    output logic                  p_FiFoEmpty_o,
    output logic                  p_FiFoFull_o,
    output logic                  p_AlmostFull_o,
    output logic [ADDR_WIDTH:0]   Count_o,
    output logic                  p_Overflow_o,
    output logic                  p_Underflow_o
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_s;
    logic [ADDR_WIDTH:0]   count_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_d;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ovf_d;
    logic                  unf_d;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  empty_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  ovf_q;
    logic                  unf_q;

`ifdef UART_TX_FIFO_TMR_EN
    logic [ADDR_WIDTH-1:0] wr_ptr_a_q, wr_ptr_b_q, wr_ptr_c_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_a_q, rd_ptr_b_q, rd_ptr_c_q;
    logic [ADDR_WIDTH:0]   count_a_q,  count_b_q,  count_c_q;

    function automatic logic [ADDR_WIDTH-1:0] vote_ptr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [ADDR_WIDTH-1:0] b,
                                                       input logic [ADDR_WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [ADDR_WIDTH:0] vote_cnt(input logic [ADDR_WIDTH:0] a,
                                                     input logic [ADDR_WIDTH:0] b,
                                                     input logic [ADDR_WIDTH:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign wr_ptr_s = vote_ptr(wr_ptr_a_q, wr_ptr_b_q, wr_ptr_c_q);
    assign rd_ptr_s = vote_ptr(rd_ptr_a_q, rd_ptr_b_q, rd_ptr_c_q);
    assign count_s  = vote_cnt(count_a_q, count_b_q, count_c_q);

    // All three copies reload the same voted next value, scrubbing any upset copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_a_q <= PTR_ZERO; wr_ptr_b_q <= PTR_ZERO; wr_ptr_c_q <= PTR_ZERO;
            rd_ptr_a_q <= PTR_ZERO; rd_ptr_b_q <= PTR_ZERO; rd_ptr_c_q <= PTR_ZERO;
            count_a_q  <= CNT_ZERO; count_b_q  <= CNT_ZERO; count_c_q  <= CNT_ZERO;
        end else begin
            wr_ptr_a_q <= wr_ptr_d; wr_ptr_b_q <= wr_ptr_d; wr_ptr_c_q <= wr_ptr_d;
            rd_ptr_a_q <= rd_ptr_d; rd_ptr_b_q <= rd_ptr_d; rd_ptr_c_q <= rd_ptr_d;
            count_a_q  <= count_d;  count_b_q  <= count_d;  count_c_q  <= count_d;
        end
    end
`else
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;

    assign wr_ptr_s = wr_ptr_q;
    assign rd_ptr_s = rd_ptr_q;
    assign count_s  = count_q;

    // Single-copy pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`endif

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_acc_s = p_RdEn_i & (count_s != CNT_ZERO);
    assign wr_acc_s = p_WrEn_i & ((count_s != DEPTH_C) | rd_acc_s);

    // Next-state pointers, occupancy and sticky error flags (set wins over clear).
    always_comb begin
        wr_ptr_d = wr_ptr_s;
        rd_ptr_d = rd_ptr_s;
        count_d  = count_s;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_s + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_s;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_s + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_s;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_s + CNT_ONE;
            2'b01:   count_d = count_s - CNT_ONE;
            default: count_d = count_s;
        endcase
        if (p_WrEn_i && !wr_acc_s) begin
            ovf_d = 1'b1;
        end else if (p_ErrClr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (p_RdEn_i && !rd_acc_s) begin
            unf_d = 1'b1;
        end else if (p_ErrClr_i) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wr_ptr_s] <= WrData_i;
        end
    end

    // Registered read data and status flags derived from the next-state count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (rd_acc_s) begin
                rdata_q <= mem_q[rd_ptr_s];
            end
            empty_q <= (count_d == CNT_ZERO);
            full_q  <= (count_d == DEPTH_C);
            afull_q <= (count_d >= AFULL_C);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign RdData_o       = rdata_q;
    assign p_FiFoEmpty_o  = empty_q;
    assign p_FiFoFull_o   = full_q;
    assign p_AlmostFull_o = afull_q;
    assign Count_o        = count_s;
    assign p_Overflow_o   = ovf_q;
    assign p_Underflow_o  = unf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, directed scenarios and random traffic.
// Define UART_TX_FIFO_TMR_EN to also exercise the write-pointer upset scenario.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_WrEn_i = 1'b0;
    logic [7:0] WrData_i = 8'h00;
    logic       p_RdEn_i = 1'b0;
    logic       p_ErrClr_i = 1'b0;
    logic [7:0] RdData_o;
    logic       p_FiFoEmpty_o, p_FiFoFull_o, p_AlmostFull_o;
    logic [4:0] Count_o;
    logic       p_Overflow_o, p_Underflow_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
        .clk(clk), .rst(rst),
        .p_WrEn_i(p_WrEn_i), .WrData_i(WrData_i),
        .p_RdEn_i(p_RdEn_i), .p_ErrClr_i(p_ErrClr_i),
        .RdData_o(RdData_o), .p_FiFoEmpty_o(p_FiFoEmpty_o),
        .p_FiFoFull_o(p_FiFoFull_o), .p_AlmostFull_o(p_AlmostFull_o),
        .Count_o(Count_o), .p_Overflow_o(p_Overflow_o), .p_Underflow_o(p_Underflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of stored bytes plus last read value and sticky flags.
    logic [7:0] m_q[$];
    logic [7:0] m_rdata = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    always @(posedge clk) begin
        bit rd_ok, wr_ok;
        if (rst) begin
            m_q.delete();
            m_rdata = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd_ok = p_RdEn_i && (m_q.size() > 0);
            wr_ok = p_WrEn_i && ((m_q.size() < 16) || rd_ok);
            m_ovf = (p_WrEn_i && !wr_ok) ? 1'b1 : (p_ErrClr_i ? 1'b0 : m_ovf);
            m_unf = (p_RdEn_i && !rd_ok) ? 1'b1 : (p_ErrClr_i ? 1'b0 : m_unf);
            if (rd_ok) m_rdata = m_q.pop_front();
            if (wr_ok) m_q.push_back(WrData_i);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(Count_o), 32'(m_q.size()));
            chk("empty", 32'(p_FiFoEmpty_o), 32'(m_q.size() == 0));
            chk("full", 32'(p_FiFoFull_o), 32'(m_q.size() == 16));
            chk("afull", 32'(p_AlmostFull_o), 32'(m_q.size() >= 12));
            chk("rdata", 32'(RdData_o), 32'(m_rdata));
            chk("ovf", 32'(p_Overflow_o), 32'(m_ovf));
            chk("unf", 32'(p_Underflow_o), 32'(m_unf));
        end
    end

    task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        p_WrEn_i = wr; WrData_i = d; p_RdEn_i = rd; p_ErrClr_i = clr;
        @(posedge clk); #1;
        p_WrEn_i = 1'b0; p_RdEn_i = 1'b0; p_ErrClr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic [7:0] tx_bytes [5] = '{8'h55, 8'h3C, 8'hC3, 8'h01, 8'hFE};

    initial begin
        int rds, busy;
        int pw, pr;
        bit r;

        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();
        chk_en = 1'b1;
        chk("rst_empty", 32'(p_FiFoEmpty_o), 32'd1);
        chk("rst_count", 32'(Count_o), 32'd0);
        chk("rst_rdata", 32'(RdData_o), 32'h00);
        chk("rst_flags", {28'd0, p_FiFoFull_o, p_AlmostFull_o, p_Overflow_o, p_Underflow_o}, 32'd0);

        // Single word round trip
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("wr1_empty", 32'(p_FiFoEmpty_o), 32'd0);
        chk("wr1_count", 32'(Count_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rd1_data", 32'(RdData_o), 32'hA5);
        chk("rd1_empty", 32'(p_FiFoEmpty_o), 32'd1);
        chk("rd1_count", 32'(Count_o), 32'd0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 10) chk("afull_below", 32'(p_AlmostFull_o), 32'd0);
            if (i == 11) chk("afull_at12", 32'(p_AlmostFull_o), 32'd1);
            if (i == 14) chk("full_at15", 32'(p_FiFoFull_o), 32'd0);
        end
        chk("full_at16", 32'(p_FiFoFull_o), 32'd1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set", 32'(p_Overflow_o), 32'd1);
        chk("ovf_count", 32'(Count_o), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_order", 32'(RdData_o), 32'(i));
        end
        chk("drain_empty", 32'(p_FiFoEmpty_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(p_Overflow_o), 32'd0);

        // Full with simultaneous read and write across pointer wrap
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
            chk("rw_data", 32'(RdData_o), (i < 16) ? 32'(i) : 32'h40 + 32'(i - 16));
            chk("rw_count", 32'(Count_o), 32'd16);
        end
        chk("rw_noovf", 32'(p_Overflow_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("rw_drain", 32'(RdData_o), 32'h44 + 32'(i));
        end

        // Underflow, clear, set-wins, no write-through
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(p_Underflow_o), 32'd1);
        chk("unf_rdata", 32'(RdData_o), 32'h53);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_clr", 32'(p_Underflow_o), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_setwins", 32'(p_Underflow_o), 32'd1);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        chk("nowt_rdata", 32'(RdData_o), 32'h53);
        chk("nowt_count", 32'(Count_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("nowt_read", 32'(RdData_o), 32'h77);
        chk("nowt_clr", 32'(p_Underflow_o), 32'd0);

        // Reset mid-stream discards contents
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_count", 32'(Count_o), 32'd0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid_rst_data", 32'(RdData_o), 32'h44);
        chk("mid_rst_cnt2", 32'(Count_o), 32'd0);

        // Tx state machine draining five bytes on a baud tick every 8 cycles
        for (int i = 0; i < 5; i++) cyc(1'b1, tx_bytes[i], 1'b0, 1'b0);
        rds = 0;
        busy = 0;
        for (int c = 0; c < 600; c++) begin
            r = 1'b0;
            if (c % 8 == 0) begin
                if (busy > 0) busy--;
                else if (!p_FiFoEmpty_o) begin
                    r = 1'b1;
                    busy = 10;
                end
            end
            cyc(1'b0, 8'h00, r, 1'b0);
            if (r) begin
                chk("tx_byte", 32'(RdData_o), (rds < 5) ? 32'(tx_bytes[rds]) : 32'hFFFF_FFFF);
                rds++;
            end
        end
        chk("tx_reads", 32'(rds), 32'd5);
        chk("tx_empty", 32'(p_FiFoEmpty_o), 32'd1);
        chk("tx_nounf", 32'(p_Underflow_o), 32'd0);

`ifdef UART_TX_FIFO_TMR_EN
        // Upset one write-pointer copy while writing; voting must hide it
        do_reset();
        cyc(1'b1, 8'hB0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        force dut.wr_ptr_b_q = 4'd9;
        cyc(1'b1, 8'hB3, 1'b0, 1'b0);
        release dut.wr_ptr_b_q;
        cyc(1'b1, 8'hB4, 1'b0, 1'b0);
        chk("tmr_count", 32'(Count_o), 32'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("tmr_order", 32'(RdData_o), 32'hB0 + 32'(i));
        end
`endif

        // Random traffic with a per-block bias; rare resets
        for (int b = 0; b < 12; b++) begin
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 299) == 0) rst = 1'b1;
                cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                    $urandom_range(0, 99) < 4);
                rst = 1'b0;
            end
        end

        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
